pipeline_hazard_ctrl: RTL and testbench

- Generalised hazard controller for the 5-stage RISC-V pipeline. It replaces the forwarding-only hazard unit.
- Provides per-operand forwarding for a parametrised number of source operands.
- Detects load-use hazards and stalls for them.
- Flushes on taken branches.
- Stalls the front end while a multi-cycle execute unit (mul/div) is busy, and aborts that unit if it runs past a watchdog limit.
- Keeps saturating stall and flush performance counters.
- Sits beside the stage registers and drives their stall/flush enables and the execute-stage operand muxes.

---
 rtl/pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Purpose : Hazard controller for a 5-stage RISC-V pipeline. It provides
//           per-operand forwarding selects and detects load-use hazards. It
//           flushes on taken branches and stalls the front end while a
//           multi-cycle execute unit is busy. A watchdog aborts that unit if
//           it overruns. Saturating stall and flush counters are also kept.
// Ports   : clk, rst (async, active-low)
//           RS_D/RS_E   packed source regs, operand k at [k*AW +: AW]
//           RD_E/M/W    destination regs of E/M/W stages
//           ResultSrcE  E-stage result select (2'b01 = load)
//           RegWriteM/W, PCSrcE, busy_i, clr_cnt_i
//           StallF/D/E, FlushD/E/M   stage register enables
//           ForwardE    2 bits per operand: 10 from M, 01 from W, 00 regfile
//           abort_o     one-cycle abort pulse, err_o sticky watchdog error
//           stall_cnt_o / flush_cnt_o  saturating performance counters
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int MAX_BUSY = 64,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*AW-1:0]   RS_D,
  input  logic [NUM_SRC*AW-1:0]   RS_E,
  input  logic [AW-1:0]           RD_E,
  input  logic [AW-1:0]           RD_M,
  input  logic [AW-1:0]           RD_W,
  input  logic [1:0]              ResultSrcE,
  input  logic                    RegWriteM,
  input  logic                    RegWriteW,
  input  logic                    PCSrcE,
  input  logic                    busy_i,
  input  logic                    clr_cnt_i,
  output logic                    StallF,
  output logic                    StallD,
  output logic                    StallE,
  output logic                    FlushD,
  output logic                    FlushE,
  output logic                    FlushM,
  output logic [2*NUM_SRC-1:0]    ForwardE,
  output logic                    abort_o,
  output logic                    err_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic [CNT_W-1:0]        flush_cnt_o
);

  // The busy count never exceeds MAX_BUSY-1, so clog2(MAX_BUSY) bits suffice.
  localparam int BW = $clog2(MAX_BUSY);
  localparam logic [BW-1:0] C_BUSY_LAST = BW'(MAX_BUSY - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       busy_cnt_q, busy_cnt_d;
  logic                err_q;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

  logic [2*NUM_SRC-1:0] fwd_w;
  logic [NUM_SRC-1:0]   lu_hit_w;
  logic                 lu_w;
  logic                 br_flush_w;

  // Per-operand forwarding and load-use match.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [AW-1:0] rs_e_k;
    logic [AW-1:0] rs_d_k;
    assign rs_e_k = RS_E[k*AW +: AW];
    assign rs_d_k = RS_D[k*AW +: AW];
    // M is the younger result, so it wins over W; x0 is never forwarded.
    assign fwd_w[2*k +: 2] =
        (RegWriteM && (RD_M != '0) && (RD_M == rs_e_k)) ? 2'b10 :
        (RegWriteW && (RD_W != '0) && (RD_W == rs_e_k)) ? 2'b01 : 2'b00;
    assign lu_hit_w[k] = (RD_E == rs_d_k);
  end

  assign lu_w = (ResultSrcE == 2'b01) && (RD_E != '0) && (|lu_hit_w);

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    ForwardE   = '0;
    abort_o    = 1'b0;
    br_flush_w = 1'b0;
    // While reset is low every combinational output stays quiet.
    if (rst) begin
      ForwardE = fwd_w;
      case (state_q)
        ST_RUN: begin
          // A branch squashes the dependent instruction, so it beats load-use.
          if (PCSrcE) begin
            FlushD     = 1'b1;
            FlushE     = 1'b1;
            br_flush_w = 1'b1;
          end else if (lu_w) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
          if (busy_i) begin
            state_d    = ST_BUSY;
            busy_cnt_d = BW'(1);
          end
        end
        ST_BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          if (!busy_i) begin
            state_d    = ST_RUN;
            busy_cnt_d = '0;
          end else if (busy_cnt_q == C_BUSY_LAST) begin
            state_d    = ST_ABORT;
            busy_cnt_d = '0;
          end else begin
            busy_cnt_d = busy_cnt_q + BW'(1);
          end
        end
        ST_ABORT: begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          abort_o = 1'b1;
          state_d = ST_RUN;
        end
        default: begin
          state_d    = ST_RUN;
          busy_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      busy_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      // Raised on entry so it is already visible during the abort cycle.
      if (state_d == ST_ABORT) begin
        err_q <= 1'b1;
      end
      if (clr_cnt_i) begin
        stall_cnt_q <= '0;
        flush_cnt_q <= '0;
      end else begin
        if (StallF && (stall_cnt_q != '1)) begin
          stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
        if (br_flush_w && (flush_cnt_q != '1)) begin
          flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Purpose : Self-checking bench for pipeline_hazard_ctrl. Two instances share
//           one stimulus: A uses default watchdog and counter sizes, B uses
//           MAX_BUSY=4 and CNT_W=4.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NS*AW-1:0] RS_D, RS_E;
  logic [AW-1:0]    RD_E, RD_M, RD_W;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM, RegWriteW, PCSrcE, busy_i, clr_cnt_i;

  logic sf_a, sd_a, se_a, fd_a, fe_a, fm_a, ab_a, er_a;
  logic sf_b, sd_b, se_b, fd_b, fe_b, fm_b, ab_b, er_b;
  logic [2*NS-1:0] fw_a, fw_b;
  logic [31:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  logic [7:0]  ctl_a, ctl_b;
  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,abort,err}
  assign ctl_a = {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, ab_a, er_a};
  assign ctl_b = {sf_b, sd_b, se_b, fd_b, fe_b, fm_b, ab_b, er_b};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.AW(AW), .NUM_SRC(NS), .MAX_BUSY(64), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .RS_D(RS_D), .RS_E(RS_E), .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .busy_i(busy_i), .clr_cnt_i(clr_cnt_i), .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
    .FlushD(fd_a), .FlushE(fe_a), .FlushM(fm_a), .ForwardE(fw_a), .abort_o(ab_a),
    .err_o(er_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

  pipeline_hazard_ctrl #(.AW(AW), .NUM_SRC(NS), .MAX_BUSY(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .RS_D(RS_D), .RS_E(RS_E), .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .busy_i(busy_i), .clr_cnt_i(clr_cnt_i), .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
    .FlushD(fd_b), .FlushE(fe_b), .FlushM(fm_b), .ForwardE(fw_b), .abort_o(ab_b),
    .err_o(er_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, how many consecutive busy cycles the
  // current episode has seen (0 = unit idle), whether this is the abort cycle,
  // sticky error, and the two counters as plain integers.
  int     m_age  [2];
  bit     m_abt  [2];
  bit     m_err  [2];
  longint m_sc   [2];
  longint m_fc   [2];
  int     m_max  [2] = '{64, 4};
  longint m_cmax [2] = '{64'hFFFF_FFFF, 64'd15};

  logic [2*NS-1:0] x_fw;
  bit x_sf [2], x_se [2], x_fd [2], x_fe [2], x_fm [2], x_ab [2];

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] x_ctl(input int i);
    return {x_sf[i], x_sf[i], x_se[i], x_fd[i], x_fe[i], x_fm[i], x_ab[i], m_err[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_age[i] = 0; m_abt[i] = 0; m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic model_eval();
    bit lu;
    lu = 0;
    x_fw = '0;
    for (int k = 0; k < NS; k++) begin
      if (ResultSrcE == 2'b01 && RD_E != 0 && RD_E == RS_D[k*AW +: AW]) lu = 1;
      if (rst) x_fw[2*k +: 2] = ref_fwd(RS_E[k*AW +: AW]);
    end
    for (int i = 0; i < 2; i++) begin
      x_sf[i] = 0; x_se[i] = 0; x_fd[i] = 0; x_fe[i] = 0; x_fm[i] = 0; x_ab[i] = 0;
      if (rst) begin
        if (m_abt[i] || m_age[i] > 0) begin
          x_sf[i] = 1; x_se[i] = 1; x_fm[i] = 1; x_ab[i] = m_abt[i];
        end else if (PCSrcE) begin
          x_fd[i] = 1; x_fe[i] = 1;
        end else if (lu) begin
          x_sf[i] = 1; x_fe[i] = 1;
        end
      end
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr_cnt_i) begin
          m_sc[i] = 0; m_fc[i] = 0;
        end else begin
          if (x_sf[i] && m_sc[i] < m_cmax[i]) m_sc[i]++;
          if (x_fd[i] && m_fc[i] < m_cmax[i]) m_fc[i]++;
        end
        if (m_abt[i]) begin
          m_abt[i] = 0;
        end else if (m_age[i] > 0) begin
          if (!busy_i) m_age[i] = 0;
          else if (m_age[i] + 1 >= m_max[i]) begin
            m_age[i] = 0; m_abt[i] = 1; m_err[i] = 1;
          end else m_age[i]++;
        end else if (busy_i) begin
          m_age[i] = 1;
        end
      end
    end
  endtask

  // Advance one clock: account for the edge in the model, land on next negedge.
  task automatic tick();
    model_eval();
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    RS_D = '0; RS_E = '0; RD_E = '0; RD_M = '0; RD_W = '0; ResultSrcE = 2'b00;
    RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; busy_i = 0; clr_cnt_i = 0;
  endtask

  task automatic do_reset();
    rst = 0; model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    RS_E = 10'($urandom_range(1, 1023)); RD_M = RS_E[4:0] | 5'd1; RS_E[4:0] = RD_M;
    RS_D = RS_E; RD_E = RD_M; ResultSrcE = 2'b01; RegWriteM = 1; RegWriteW = 1;
    RD_W = RD_M; PCSrcE = 1; busy_i = 1; clr_cnt_i = 0;
    @(negedge clk); #2;
    checks++;
    if (ctl_a !== 8'h00 || fw_a !== 4'b0000 || sc_a !== 0 || fc_a !== 0) begin
      errors++; $display("FAIL reset_a ctl=%b fw=%b sc=%0d fc=%0d required all zero", ctl_a, fw_a, sc_a, fc_a);
    end
    checks++;
    if (ctl_b !== 8'h00 || fw_b !== 4'b0000 || sc_b !== 0 || fc_b !== 0) begin
      errors++; $display("FAIL reset_b ctl=%b fw=%b sc=%0d fc=%0d required all zero", ctl_b, fw_b, sc_b, fc_b);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1;
  endtask

  task automatic test_forwarding();
    idle_inputs();
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; RS_E = {5'd0, 5'd5};
    #2; model_eval();
    checks++;
    if (fw_a !== 4'b0010 || fw_a !== x_fw) begin
      errors++; $display("FAIL fwd_m_prio got=%b required=0010", fw_a);
    end
    tick();
    RegWriteM = 0;
    #2; model_eval();
    checks++;
    if (fw_a !== 4'b0001 || fw_b !== 4'b0001) begin
      errors++; $display("FAIL fwd_w got_a=%b got_b=%b required=0001", fw_a, fw_b);
    end
    tick();
    RegWriteM = 1; RD_M = 3; RegWriteW = 1; RD_W = 9; RS_E = {5'd9, 5'd3};
    #2;
    checks++;
    if (fw_a !== 4'b0110) begin
      errors++; $display("FAIL fwd_two_ops got=%b required=0110", fw_a);
    end
    tick();
    RD_M = 0; RD_W = 0; RS_E = {5'd0, 5'd0};
    #2;
    checks++;
    if (fw_a !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0 got=%b required=0000", fw_a);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_load_use();
    idle_inputs(); clr_cnt_i = 1; tick(); clr_cnt_i = 0;
    ResultSrcE = 2'b01; RD_E = 7; RS_D = {5'd7, 5'd2};
    #2;
    checks++;
    if (ctl_a !== 8'b1100_1000 || sc_a !== 0) begin
      errors++; $display("FAIL load_use_stall ctl=%b sc=%0d required ctl=11001000 sc=0", ctl_a, sc_a);
    end
    tick();
    idle_inputs();
    #2;
    checks++;
    if (ctl_a !== 8'h00 || sc_a !== 1 || sc_b !== 1) begin
      errors++; $display("FAIL load_use_count ctl=%b sc_a=%0d sc_b=%0d required ctl=0 sc=1", ctl_a, sc_a, sc_b);
    end
    tick();
    ResultSrcE = 2'b01; RD_E = 0; RS_D = {5'd7, 5'd0};
    #2;
    checks++;
    if (ctl_a !== 8'h00) begin
      errors++; $display("FAIL load_use_x0 ctl=%b required=00000000", ctl_a);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_vs_lu();
    idle_inputs(); clr_cnt_i = 1; tick(); clr_cnt_i = 0;
    ResultSrcE = 2'b01; RD_E = 7; RS_D = {5'd7, 5'd2}; PCSrcE = 1;
    #2;
    checks++;
    if (ctl_a !== 8'b0001_1000) begin
      errors++; $display("FAIL branch_prio ctl=%b required=00011000", ctl_a);
    end
    tick();
    idle_inputs();
    #2;
    checks++;
    if (fc_a !== 1 || sc_a !== 0 || fc_b !== 1) begin
      errors++; $display("FAIL branch_count fc=%0d sc=%0d required fc=1 sc=0", fc_a, sc_a);
    end
    tick();
  endtask

  task automatic test_multicycle();
    logic [7:0] exp;
    do_reset();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      busy_i = (c < 4);
      #2; model_eval();
      exp = (c == 0 || c == 5) ? 8'h00 : 8'b1110_0100;
      checks++;
      if (ctl_a !== exp) begin
        errors++; $display("FAIL busy_cycle%0d ctl=%b required=%b", c, ctl_a, exp);
      end
      checks++;
      if (ctl_b !== x_ctl(1)) begin
        errors++; $display("FAIL busy_b_cycle%0d ctl=%b required=%b", c, ctl_b, x_ctl(1));
      end
      if (c == 5) begin
        checks++;
        if (sc_a !== 4 || er_a !== 1'b0) begin
          errors++; $display("FAIL busy_done sc=%0d err=%b required sc=4 err=0", sc_a, er_a);
        end
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    idle_inputs();
    busy_i = 1;
    for (int c = 1; c <= 9; c++) begin
      #2; model_eval();
      checks++;
      if (ab_b !== (c == 5) || er_b !== (c >= 5)) begin
        errors++; $display("FAIL watchdog_c%0d abort=%b err=%b required abort=%b err=%b",
                           c, ab_b, er_b, (c == 5), (c >= 5));
      end
      checks++;
      if (ctl_a !== x_ctl(0)) begin
        errors++; $display("FAIL watchdog_a_c%0d ctl=%b required=%b", c, ctl_a, x_ctl(0));
      end
      tick();
    end
    busy_i = 0;
    tick(); tick();
    #2;
    checks++;
    if (er_b !== 1'b1 || ab_b !== 1'b0 || er_a !== 1'b0) begin
      errors++; $display("FAIL err_sticky err_b=%b abort_b=%b err_a=%b required 1 0 0", er_b, ab_b, er_a);
    end
    rst = 0; model_reset();
    #1;
    checks++;
    if (er_b !== 1'b0) begin
      errors++; $display("FAIL err_clear err_b=%b required=0", er_b);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_counters();
    idle_inputs(); clr_cnt_i = 1; tick(); clr_cnt_i = 0;
    ResultSrcE = 2'b01; RD_E = 12; RS_D = {5'd12, 5'd1};
    for (int n = 0; n < 20; n++) tick();
    idle_inputs();
    #2;
    checks++;
    if (sc_b !== 4'd15 || sc_a !== 32'd20) begin
      errors++; $display("FAIL stall_saturate sc_b=%0d sc_a=%0d required 15 20", sc_b, sc_a);
    end
    tick();
    ResultSrcE = 2'b01; RD_E = 12; RS_D = {5'd12, 5'd1}; clr_cnt_i = 1;
    #2;
    checks++;
    if (sf_a !== 1'b1) begin
      errors++; $display("FAIL clr_with_stall_sf got=%b required=1", sf_a);
    end
    tick();
    idle_inputs();
    #2;
    checks++;
    if (sc_a !== 0 || sc_b !== 0 || fc_a !== 0) begin
      errors++; $display("FAIL clr_override sc_a=%0d sc_b=%0d fc_a=%0d required 0", sc_a, sc_b, fc_a);
    end
    tick();
  endtask

  task automatic test_reset_busy();
    idle_inputs();
    RegWriteM = 1; RD_M = 4; RS_E = {5'd4, 5'd4};
    busy_i = 1;
    tick(); tick();
    #2;
    checks++;
    if (ctl_a !== 8'b1110_0100) begin
      errors++; $display("FAIL pre_reset_busy ctl=%b required=11100100", ctl_a);
    end
    rst = 0; model_reset();
    #1;
    checks++;
    if (ctl_a !== 8'h00 || ctl_b !== 8'h00 || fw_a !== 0 || fw_b !== 0 || sc_a !== 0 || sc_b !== 0) begin
      errors++; $display("FAIL reset_in_busy ctl_a=%b ctl_b=%b fw_a=%b sc_a=%0d required all zero",
                         ctl_a, ctl_b, fw_a, sc_a);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1;
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      RS_D = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      RS_E = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      RD_E = 5'($urandom_range(0, 3));
      RD_M = 5'($urandom_range(0, 3));
      RD_W = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 4) == 0);
      clr_cnt_i  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) busy_i = ~busy_i;
      #2; model_eval();
      checks++;
      if (fw_a !== x_fw || fw_b !== x_fw) begin
        errors++; $display("FAIL rnd_fwd n=%0d a=%b b=%b required=%b", n, fw_a, fw_b, x_fw);
      end
      checks++;
      if (ctl_a !== x_ctl(0)) begin
        errors++; $display("FAIL rnd_ctl_a n=%0d got=%b required=%b", n, ctl_a, x_ctl(0));
      end
      checks++;
      if (ctl_b !== x_ctl(1)) begin
        errors++; $display("FAIL rnd_ctl_b n=%0d got=%b required=%b", n, ctl_b, x_ctl(1));
      end
      checks++;
      if (sc_a !== 32'(m_sc[0]) || fc_a !== 32'(m_fc[0]) ||
          sc_b !== 4'(m_sc[1]) || fc_b !== 4'(m_fc[1])) begin
        errors++; $display("FAIL rnd_cnt n=%0d a=%0d/%0d b=%0d/%0d required a=%0d/%0d b=%0d/%0d",
                           n, sc_a, fc_a, sc_b, fc_b, m_sc[0], m_fc[0], m_sc[1], m_fc[1]);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lu();
    test_multicycle();
    test_watchdog();
    test_counters();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
